// File: rtl/softmax_norm_seq.sv
// Softmax normalization sequencer: buffers one vector of signed fixed-point
// elements while summing them, then hands each element and the sum to an
// external divider one at a time and streams the quotients out.
module softmax_norm_seq #(
  parameter int WIDTH   = 16,
  parameter int FRAC_SZ = 12,
  parameter int VEC_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             div_start,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic [WIDTH-1:0] div_quot,
  input  logic             div_done,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             div_zero
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(VEC_LEN - 1);
  localparam logic [WIDTH-1:0] SUM_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SUM_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  if (VEC_LEN < 2 || FRAC_SZ >= WIDTH) begin : g_param_check
    $error("softmax_norm_seq: need VEC_LEN >= 2 and FRAC_SZ < WIDTH");
  end

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, OUT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] buf_q [VEC_LEN];
  logic [WIDTH-1:0] buf_d [VEC_LEN];
  logic             in_ready_q, in_ready_d;
  logic             div_start_q, div_start_d;
  logic [WIDTH-1:0] div_num_q, div_num_d;
  logic [WIDTH-1:0] div_den_q, div_den_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_sat;
  logic [CW-1:0]    idx_inc;

  // Next-state logic: accumulate in LOAD, one divide per element, hold output until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    in_ready_d  = in_ready_q;
    div_start_d = 1'b0;
    div_num_d   = div_num_q;
    div_den_d   = div_den_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    div_zero_d  = div_zero_q;
    idx_inc     = idx_q + 1'b1;
    sum_ext     = {sum_q[WIDTH-1], sum_q} + {in_data[WIDTH-1], in_data};
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      sum_sat = sum_ext[WIDTH] ? SUM_MIN : SUM_MAX;
    end else begin
      sum_sat = sum_ext[WIDTH-1:0];
    end

    case (state_q)
      LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          buf_d[cnt_q] = in_data;
          sum_d        = sum_sat;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            in_ready_d = 1'b0;
            idx_d      = '0;
            if (sum_sat == '0) begin
              state_d     = OUT;
              out_valid_d = 1'b1;
              out_data_d  = '0;
              out_last_d  = 1'b0;
              div_zero_d  = 1'b1;
            end else begin
              state_d     = ISSUE;
              div_start_d = 1'b1;
              div_num_d   = buf_q[0];
              div_den_d   = sum_sat;
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          out_data_d  = div_quot;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == LAST_IDX);
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_inc;
            if (div_zero_q) begin
              out_data_d = '0;
              out_last_d = (idx_inc == LAST_IDX);
            end else begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              state_d     = ISSUE;
              div_start_d = 1'b1;
              div_num_d   = buf_q[idx_inc];
              div_den_d   = sum_q;
            end
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            div_zero_d  = 1'b0;
            cnt_d       = '0;
            sum_d       = '0;
            idx_d       = '0;
            in_ready_d  = 1'b1;
            state_d     = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and output registers; reset discards any partially loaded vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      for (int i = 0; i < VEC_LEN; i++) buf_q[i] <= '0;
      in_ready_q  <= 1'b0;
      div_start_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      div_start_q <= div_start_d;
      div_num_q   <= div_num_d;
      div_den_q   <= div_den_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign div_start = div_start_q;
  assign div_num   = div_num_q;
  assign div_den   = div_den_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_softmax_norm_seq.sv
// Bench for softmax_norm_seq with VEC_LEN=4: a 3-cycle divider model and a
// vector-level reference model of the expected divider requests and outputs.
module tb_softmax_norm_seq;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk, reset, in_valid, in_ready, div_start, div_done;
  logic         out_valid, out_last, out_ready, div_zero;
  logic [W-1:0] in_data, div_num, div_den, div_quot, out_data;

  int vectors = 0;
  int miscompares = 0;
  int start_num[$];
  int start_den[$];
  int out_d[$];
  int out_l[$];
  int accepted = 0;
  bit inject_done = 0;

  softmax_norm_seq #(.WIDTH(W), .FRAC_SZ(12), .VEC_LEN(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .div_start(div_start), .div_num(div_num),
    .div_den(div_den), .div_quot(div_quot), .div_done(div_done),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .div_zero(div_zero)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // External divider: quotient (num << 12) / den, done pulse 3 cycles after the start is seen.
  initial begin
    int cd;
    bit busy;
    int q;
    busy = 0; cd = 0; q = 0;
    div_done = 0; div_quot = '0;
    forever begin
      @(posedge clk); #2;
      div_done = 0;
      if (inject_done) begin
        div_done = 1;
        div_quot = 16'h1234;
      end
      if (busy) begin
        cd--;
        if (cd == 0) begin
          div_done = 1;
          div_quot = 16'(q);
          busy = 0;
        end
      end
      if (div_start) begin
        busy = 1;
        cd = 3;
        q = (div_den == '0) ? 0 :
            (int'($signed(div_num)) * 4096) / int'($signed(div_den));
      end
    end
  end

  // Record every divider request, output handshake and accepted input.
  always @(negedge clk) begin
    if (reset) begin
      if (div_start) begin
        start_num.push_back(int'($signed(div_num)));
        start_den.push_back(int'($signed(div_den)));
      end
      if (out_valid && out_ready) begin
        out_d.push_back(int'($signed(out_data)));
        out_l.push_back(int'(out_last));
      end
      if (in_valid && in_ready) accepted++;
    end
  end

  // Reference: saturating sum, then element*4096/sum truncated to 16 bits; zero sum gives zeros.
  function automatic void ref_model(input int v[N], output int sum, output int q[N]);
    logic [W-1:0] t;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      sum += v[i];
      if (sum > 32767) sum = 32767;
      else if (sum < -32768) sum = -32768;
    end
    for (int i = 0; i < N; i++) begin
      if (sum == 0) q[i] = 0;
      else begin
        t = 16'((v[i] * 4096) / sum);
        q[i] = int'($signed(t));
      end
    end
  endfunction

  task automatic clear_mon();
    start_num.delete(); start_den.delete();
    out_d.delete(); out_l.delete();
    accepted = 0;
  endtask

  task automatic push_one(input int d);
    int t;
    t = 0;
    in_valid = 1;
    in_data = 16'(d);
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL push_timeout in_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic push_vec(input int v[N]);
    for (int i = 0; i < N; i++) push_one(v[i]);
  endtask

  task automatic drain(input int n, input bit rnd);
    int t;
    t = 0;
    while (out_d.size() < n && t < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    out_ready = 0;
    if (out_d.size() < n) begin
      vectors++; miscompares++;
      $display("[TB] FAIL drain_timeout outputs got %0d want %0d", out_d.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, div_start, out_valid, out_last, div_zero} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 00000", {in_ready, div_start, out_valid, out_last, div_zero});
    end
    vectors++;
    if ({div_num, div_den, out_data} !== 48'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got %h want 0", {div_num, div_den, out_data});
    end
    reset = 1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready_rise got %b want 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    int v[N];
    int sum;
    int q[N];
    v = '{4096, 4096, 4096, 4096};
    ref_model(v, sum, q);
    clear_mon();
    push_vec(v);
    vectors++;
    if (div_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nominal_start_latency div_start got %b want 1", div_start);
    end
    drain(N, 0);
    vectors++;
    if (start_num.size() != N) begin
      miscompares++;
      $display("[TB] FAIL nominal_start_count got %0d want %0d", start_num.size(), N);
    end
    for (int i = 0; i < N && i < start_num.size(); i++) begin
      vectors++;
      if (start_num[i] !== 4096 || start_den[i] !== 16384) begin
        miscompares++;
        $display("[TB] FAIL nominal_req%0d got %0d/%0d want 4096/16384", i, start_num[i], start_den[i]);
      end
    end
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== q[i] || out_l[i] !== int'(i == N-1)) begin
        miscompares++;
        $display("[TB] FAIL nominal_out%0d got %0d last %0d want %0d last %0d", i, out_d[i], out_l[i], q[i], i == N-1);
      end
    end
  endtask

  task automatic test_zero_sum();
    int v[N];
    v = '{4096, -4096, 0, 0};
    clear_mon();
    push_vec(v);
    vectors++;
    if ({div_zero, out_valid} !== 2'b11 || out_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL zero_entry got zero %b valid %b data %0d want 1 1 0", div_zero, out_valid, out_data);
    end
    drain(N, 0);
    vectors++;
    if (start_num.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_no_start got %0d starts want 0", start_num.size());
    end
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== 0 || out_l[i] !== int'(i == N-1)) begin
        miscompares++;
        $display("[TB] FAIL zero_out%0d got %0d last %0d want 0 last %0d", i, out_d[i], out_l[i], i == N-1);
      end
    end
    vectors++;
    if ({div_zero, out_valid, in_ready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL zero_exit got zero/valid/ready %b want 001", {div_zero, out_valid, in_ready});
    end
  endtask

  task automatic test_saturation();
    int v[N];
    v = '{30000, 30000, 30000, 30000};
    clear_mon();
    push_vec(v);
    drain(N, 0);
    for (int i = 0; i < N && i < start_den.size(); i++) begin
      vectors++;
      if (start_den[i] !== 32767) begin
        miscompares++;
        $display("[TB] FAIL sat_den%0d got %0d want 32767", i, start_den[i]);
      end
    end
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== (30000 * 4096) / 32767) begin
        miscompares++;
        $display("[TB] FAIL sat_out%0d got %0d want %0d", i, out_d[i], (30000 * 4096) / 32767);
      end
    end
  endtask

  task automatic test_backpressure();
    int v[N];
    int sum;
    int q[N];
    int t;
    int nstart;
    logic [W-1:0] held_d;
    logic held_l;
    v = '{1000, 2000, 3000, 4000};
    ref_model(v, sum, q);
    clear_mon();
    push_vec(v);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_wait_valid got %b want 1", out_valid);
    end
    held_d = out_data;
    held_l = out_last;
    nstart = start_num.size();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_data !== held_d || out_last !== held_l || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d got %0d/%b/%b want %0d/%b/1", i, out_data, out_last, out_valid, held_d, held_l);
      end
    end
    vectors++;
    if (start_num.size() != nstart) begin
      miscompares++;
      $display("[TB] FAIL bp_no_start got %0d starts want %0d", start_num.size(), nstart);
    end
    drain(N, 0);
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== q[i] || out_l[i] !== int'(i == N-1)) begin
        miscompares++;
        $display("[TB] FAIL bp_out%0d got %0d last %0d want %0d last %0d", i, out_d[i], out_l[i], q[i], i == N-1);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int v[N];
    int bad;
    v = '{4096, 4096, 4096, 4096};
    clear_mon();
    push_vec(v);
    @(posedge clk); #1;
    reset = 0;
    #1;
    vectors++;
    if ({in_ready, div_start, out_valid, out_last, div_zero} !== 5'b0 ||
        {div_num, div_den, out_data} !== 48'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_wait_clear got %b %h want 0", {in_ready, div_start, out_valid, out_last, div_zero}, {div_num, div_den, out_data});
    end
    @(posedge clk); #1;
    reset = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || div_start !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_wait_stale_done got %0d active cycles want 0", bad);
    end
    v = '{2048, 2048, 2048, 2048};
    clear_mon();
    push_vec(v);
    drain(N, 0);
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== 1024) begin
        miscompares++;
        $display("[TB] FAIL rst_wait_next%0d got %0d want 1024", i, out_d[i]);
      end
    end
  endtask

  task automatic test_ignore();
    int v[N];
    int sum;
    int q[N];
    v = '{512, 1024, 1536, 2048};
    ref_model(v, sum, q);
    clear_mon();
    push_one(v[0]);
    push_one(v[1]);
    inject_done = 1;
    @(posedge clk); #1;
    inject_done = 0;
    @(posedge clk); #1;
    push_one(v[2]);
    push_one(v[3]);
    in_valid = 1;
    in_data = 16'h7fff;
    drain(N-1, 0);
    in_valid = 0;
    drain(N, 0);
    vectors++;
    if (accepted != N) begin
      miscompares++;
      $display("[TB] FAIL ignore_accepted got %0d want %0d", accepted, N);
    end
    for (int i = 0; i < N && i < out_d.size(); i++) begin
      vectors++;
      if (out_d[i] !== q[i]) begin
        miscompares++;
        $display("[TB] FAIL ignore_out%0d got %0d want %0d", i, out_d[i], q[i]);
      end
    end
  endtask

  task automatic test_random();
    int v[N];
    int sum;
    int q[N];
    int nexp;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        if (it % 2 == 0) v[i] = int'($urandom_range(0, 4000)) - 2000;
        else v[i] = int'($signed(16'($urandom_range(0, 65535))));
      end
      ref_model(v, sum, q);
      nexp = (sum == 0) ? 0 : N;
      clear_mon();
      push_vec(v);
      drain(N, 1);
      vectors++;
      if (start_num.size() != nexp) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_starts got %0d want %0d", it, start_num.size(), nexp);
      end
      for (int i = 0; i < start_num.size() && i < nexp; i++) begin
        vectors++;
        if (start_num[i] !== v[i] || start_den[i] !== sum) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_req%0d got %0d/%0d want %0d/%0d", it, i, start_num[i], start_den[i], v[i], sum);
        end
      end
      for (int i = 0; i < N && i < out_d.size(); i++) begin
        vectors++;
        if (out_d[i] !== q[i] || out_l[i] !== int'(i == N-1)) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_out%0d got %0d last %0d want %0d last %0d", it, i, out_d[i], out_l[i], q[i], i == N-1);
        end
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_nominal();
    test_zero_sum();
    test_saturation();
    test_backpressure();
    test_reset_in_wait();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/softmax_norm_seq.md
SOFTMAX_NORM_SEQ -- requirements
Module: softmax_norm_seq

Interface
REQ-001 Parameter WIDTH, default 16, data word width (signed Q4.12).
REQ-002 Parameter FRAC_SZ, default 12, fractional bits.
REQ-003 Parameter VEC_LEN, default 8, elements per vector (>=2).
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_data  input  WIDTH  signed element (Q4.12).
REQ-008 in_ready  output  1  block accepts element.
REQ-009 div_start  output  1  one-cycle start pulse to divider.
REQ-010 div_num  output  WIDTH  divider numerator.
REQ-011 div_den  output  WIDTH  divider denominator.
REQ-012 div_quot  input  WIDTH  divider quotient.
REQ-013 div_done  input  1  divider result valid.
REQ-014 out_valid  output  1  normalized element valid.
REQ-015 out_data  output  WIDTH  normalized element (Q4.12).
REQ-016 out_last  output  1  marks final element of vector, qualified by out_valid.
REQ-017 div_zero  output  1  current vector sum was zero.

Function
REQ-018 The block SHALL implement FSM states LOAD, ISSUE, WAIT, OUT.
REQ-019 All outputs SHALL be registered.
REQ-020 LOAD: in_ready=1; each in_valid&in_ready cycle SHALL store in_data into buf[cnt], add it into sum, and increment cnt.
REQ-021 Sum SHALL be accumulated with saturation to [-32768, 32767] for WIDTH=16 (signed WIDTH-bit limits in general).
REQ-022 On acceptance of element VEC_LEN-1, the block SHALL clear in_ready on the next edge, reset idx to 0, and enter ISSUE, or OUT with out_data=0 if the final sum is 0.
REQ-023 ISSUE: the block SHALL drive div_start=1 for exactly one cycle with div_num=buf[idx] and div_den=sum, then enter WAIT.
REQ-024 div_num/div_den SHALL hold stable from the div_start cycle until div_done is sampled high.
REQ-025 WAIT: on first cycle div_done=1, the block SHALL latch div_quot into out_data, set out_valid=1, set out_last=(idx==VEC_LEN-1), and enter OUT.
REQ-026 div_done SHALL be ignored in LOAD, ISSUE and OUT.
REQ-027 OUT: out_data, out_last and out_valid SHALL hold stable until out_ready=1.
REQ-028 On the out handshake, if idx<VEC_LEN-1, the block SHALL increment idx and enter ISSUE (zero-sum path: stay in OUT with next out_data=0); otherwise it SHALL clear out_valid and div_zero, clear cnt and sum, and return to LOAD.
REQ-029 If the sum is zero, div_zero SHALL be 1 from end of LOAD until the last out handshake, no div_start SHALL be issued, and VEC_LEN outputs of 0 SHALL be produced.
REQ-030 Latency: div_start SHALL assert 1 cycle after the last input handshake; out_valid SHALL assert 1 cycle after div_done.
REQ-031 Negative sums SHALL be forwarded unchanged as div_den.
REQ-032 in_valid during ISSUE/WAIT/OUT SHALL be ignored (in_ready=0); no element is lost or duplicated.

Reset
REQ-033 reset low SHALL immediately force state=LOAD, cnt=idx=0, sum=0, and in_ready, div_start, div_num, div_den, out_valid, out_data, out_last, div_zero all to 0.
REQ-034 in_ready SHALL rise on the first rising edge after reset deasserts.
REQ-035 Reset asserted mid-vector, including during WAIT, SHALL discard partial state; any later div_done SHALL be ignored, and the next vector SHALL process correctly.

Verification
REQ-036 VEC_LEN=4, inputs 4096x4, divider model num/den<<12 with 3-cycle latency -> four div_start pulses with num=4096 and den=16384, outputs 1024x4, out_last on the 4th only.
REQ-037 Inputs 4096,-4096,0,0 -> no div_start, div_zero=1, outputs 0,0,0,0, div_zero=0 after the last handshake.
REQ-038 Inputs 30000x4 -> div_den=32767, outputs 30000*4096/32767 truncated.
REQ-039 out_ready held low 5 cycles in OUT -> out_data/out_last stable, no new div_start until handshake.
REQ-040 reset pulsed low during WAIT, then div_done high -> all outputs 0, no out_valid; the following vector 2048x4 yields 1024x4.
REQ-041 div_done pulsed during LOAD and in_valid held high during WAIT -> ignored; exactly VEC_LEN inputs accepted per vector.
